// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the score arbiter.
//   * source indices for the four event sources
//   * point weights per source and a lookup helper
//   * pending-counter width / saturation value
//   * FSM state encoding
package game_pkg;

    localparam int NUM_SRC   = 4;

    localparam int SRC_WARN  = 0;
    localparam int SRC_ERR1  = 1;
    localparam int SRC_ERR2  = 2;
    localparam int SRC_BONUS = 3;

    localparam logic [6:0] W_WARN  = 7'd10;
    localparam logic [6:0] W_ERR1  = 7'd15;
    localparam logic [6:0] W_ERR2  = 7'd20;
    localparam logic [6:0] W_BONUS = 7'd100;

    localparam int         CNT_W   = 3;
    localparam logic [2:0] CNT_MAX = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Points credited when source idx is granted.
    function automatic logic [6:0] weight_of(input logic [1:0] idx);
        logic [6:0] w;
        case (idx)
            2'(SRC_WARN):  w = W_WARN;
            2'(SRC_ERR1):  w = W_ERR1;
            2'(SRC_ERR2):  w = W_ERR2;
            default:       w = W_BONUS;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- combinational 4-way round-robin selector.
// Ports:
//   req_i   [3:0]  request vector (one bit per source)
//   ptr_i   [1:0]  index holding the highest priority this cycle
//   gnt_o   [3:0]  one-hot grant (all zero when no request)
//   idx_o   [1:0]  binary index of the granted source
//   valid_o        high when any request was granted
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    logic [1:0] cand;

    // Walk priorities from lowest to highest so the last hit (closest to
    // ptr_i) is the one that sticks.
    always_comb begin
        gnt_o   = '0;
        idx_o   = ptr_i;
        valid_o = 1'b0;
        cand    = ptr_i;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_i + k[1:0];
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_arbiter.sv
// score_arbiter -- queues scoring events from four sources, grants one per
// cycle round-robin, accumulates a saturating score and advances the stage.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        pulse: leave IDLE and enter PLAY at stage 1
//   freeze       level: suspend grants/score, requests keep queueing
//   evt_req[3:0] event pulses: warning, error1, error2, stage bonus
//   grant[3:0]   registered one-hot grant of the source credited this cycle
//   pend_full    per-source flag, pending count at 7
//   score[9:0]   registered accumulated score
//   stage[3:0]   registered stage, 0 = not started
//   stage_up     one-cycle pulse on each stage increment
module score_arbiter
    import game_pkg::*;
#(
    parameter int GOAL_SCORE = 100,
    parameter int SCORE_MAX  = 999,
    parameter int STAGE_MAX  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       freeze,
    input  logic [3:0] evt_req,
    output logic [3:0] grant,
    output logic [3:0] pend_full,
    output logic [9:0] score,
    output logic [3:0] stage,
    output logic       stage_up
);

    localparam logic [10:0] SCORE_CAP_W = 11'(SCORE_MAX);
    localparam logic [9:0]  SCORE_CAP   = 10'(SCORE_MAX);
    localparam logic [15:0] GOAL_W      = 16'(GOAL_SCORE);
    localparam logic [3:0]  STAGE_CAP   = 4'(STAGE_MAX);

    state_t                         state_q, state_d;
    logic [1:0]                     ptr_q, ptr_d;
    logic [NUM_SRC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]                     grant_q, grant_d;
    logic [9:0]                     score_q, score_d;
    logic [3:0]                     stage_q, stage_d;
    logic                           stage_up_q, stage_up_d;

    logic [3:0]  req_vec;
    logic [3:0]  arb_gnt;
    logic [1:0]  arb_idx;
    logic        arb_valid;
    logic        play;
    logic        arb_en;
    logic [10:0] score_sum;
    logic [15:0] stage_goal;

    assign play   = (state_q == ST_PLAY);
    assign arb_en = play && !freeze;

    rr_arbiter4 u_arb (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign grant_d = arb_en ? arb_gnt : 4'b0000;

    // Pending counters: request and grant on the same source cancel out;
    // a lone request at 7 is dropped.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc           = play && evt_req[gi];
            assign dec           = grant_d[gi];
            assign req_vec[gi]   = (cnt_q[gi] != '0);
            assign pend_full[gi] = (cnt_q[gi] == CNT_MAX);
            assign cnt_d[gi] = (inc && !dec && cnt_q[gi] != CNT_MAX) ? cnt_q[gi] + 3'd1 :
                               (dec && !inc)                         ? cnt_q[gi] - 3'd1 :
                                                                       cnt_q[gi];
        end
    endgenerate

    // Widened add so saturation happens before any wrap.
    assign score_sum  = {1'b0, score_q} + {4'b0000, weight_of(arb_idx)};
    assign stage_goal = 16'(stage_q) * GOAL_W;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        score_d    = score_q;
        stage_d    = stage_q;
        stage_up_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    stage_d = 4'd1;
                end
            end
            ST_PLAY: begin
                // Uses the registered score, so the stage trails the score by a cycle.
                if ({6'b000000, score_q} >= stage_goal && stage_q < STAGE_CAP) begin
                    stage_d    = stage_q + 4'd1;
                    stage_up_d = 1'b1;
                end
                if (arb_en && arb_valid) begin
                    ptr_d   = arb_idx + 2'd1;
                    score_d = (score_sum > SCORE_CAP_W) ? SCORE_CAP : score_sum[9:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            cnt_q      <= '0;
            grant_q    <= 4'b0000;
            score_q    <= 10'd0;
            stage_q    <= 4'd0;
            stage_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            score_q    <= score_d;
            stage_q    <= stage_d;
            stage_up_q <= stage_up_d;
        end
    end

    assign grant    = grant_q;
    assign score    = score_q;
    assign stage    = stage_q;
    assign stage_up = stage_up_q;

endmodule

// File: tb/tb_score_arbiter.sv
// tb_score_arbiter -- directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the game rules.
module tb_score_arbiter;

    localparam int GOAL  = 100;
    localparam int SMAX  = 999;
    localparam int STMAX = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] evt_req = 4'b0000;
    logic [3:0] grant;
    logic [3:0] pend_full;
    logic [9:0] score;
    logic [3:0] stage;
    logic       stage_up;

    always #5 clk = ~clk;

    score_arbiter #(
        .GOAL_SCORE (GOAL),
        .SCORE_MAX  (SMAX),
        .STAGE_MAX  (STMAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .freeze    (freeze),
        .evt_req   (evt_req),
        .grant     (grant),
        .pend_full (pend_full),
        .score     (score),
        .stage     (stage),
        .stage_up  (stage_up)
    );

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    // Behavioural model state
    int m_cnt[4];
    int m_ptr, m_score, m_stage, m_grant, m_stup;
    bit m_play;
    int weights[4] = '{10, 15, 20, 100};

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ptr = 0; m_score = 0; m_stage = 0; m_grant = 0; m_stup = 0; m_play = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_step(input logic [3:0] e, input logic s, input logic f);
        int g;
        m_grant = 0;
        m_stup  = 0;
        if (!m_play) begin
            if (s) begin
                m_play  = 1;
                m_stage = 1;
            end
        end else begin
            if (m_score >= m_stage * GOAL && m_stage < STMAX) begin
                m_stage++;
                m_stup = 1;
            end
            g = -1;
            if (!f) begin
                for (int k = 0; k < 4; k++)
                    if (g < 0 && m_cnt[(m_ptr + k) % 4] > 0) g = (m_ptr + k) % 4;
            end
            if (g >= 0) begin
                m_grant = 1 << g;
                m_cnt[g]--;
                m_score = (m_score + weights[g] > SMAX) ? SMAX : m_score + weights[g];
                m_ptr = (g + 1) % 4;
            end
            for (int i = 0; i < 4; i++)
                if (e[i] && m_cnt[i] < 7) m_cnt[i]++;
        end
    endtask

    task automatic compare_all();
        int pf;
        pf = 0;
        for (int i = 0; i < 4; i++) if (m_cnt[i] == 7) pf |= (1 << i);
        check_eq("grant",     int'(grant),     m_grant);
        check_eq("score",     int'(score),     m_score);
        check_eq("stage",     int'(stage),     m_stage);
        check_eq("stage_up",  int'(stage_up),  m_stup);
        check_eq("pend_full", int'(pend_full), pf);
    endtask

    task automatic step(input logic [3:0] e, input logic s, input logic f);
        evt_req = e;
        start   = s;
        freeze  = f;
        @(posedge clk);
        model_step(e, s, f);
        #1;
        $display("[%s] t=%0t evt=%b start=%b frz=%b -> grant=%b score=%0d stage=%0d up=%b full=%b",
                 phase, $time, e, s, f, grant, score, stage, stage_up, pend_full);
        compare_all();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        evt_req = 4'b0000;
        start   = 1'b0;
        freeze  = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int base;

    initial begin
        model_reset();
        #2;
        phase = "reset";
        compare_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single warning right after start
        phase = "single";
        step(4'b0000, 1'b1, 1'b0);
        check_eq("stage_after_start", int'(stage), 1);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("grant_warn", int'(grant), 1);
        check_eq("score_warn", int'(score), 10);

        // Three sources in one cycle, round-robin drain
        phase = "three";
        do_reset();
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("g0", int'(grant), 1);  check_eq("s0", int'(score), 10);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("g1", int'(grant), 2);  check_eq("s1", int'(score), 25);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("g2", int'(grant), 4);  check_eq("s2", int'(score), 45);

        // Saturate error2 under freeze, then drain seven
        phase = "freeze";
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b1);
        check_eq("pend_full2", int'(pend_full[2]), 1);
        base = int'(score);
        for (int i = 0; i < 7; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check_eq("drain_grant", int'(grant), 4);
        end
        check_eq("drain_score", int'(score), base + 140);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("drain_done", int'(grant), 0);

        // Score 95 then error1 crosses the first goal
        phase = "stage";
        do_reset();
        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score95", int'(score), 95);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score110", int'(score), 110);
        check_eq("stage_lag", int'(stage), 1);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("stage2", int'(stage), 2);
        check_eq("up_pulse", int'(stage_up), 1);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("up_single", int'(stage_up), 0);

        // Climb to 990, then saturate at 999
        phase = "sat";
        for (int i = 0; i < 8; i++) step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score910", int'(score), 910);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score990", int'(score), 990);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score999a", int'(score), 999);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("score999b", int'(score), 999);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, 1'b0);
        check_eq("stage_cap", int'(stage), STMAX);
        check_eq("stage_cap_up", int'(stage_up), 0);

        // Reset in the middle of a drain
        phase = "middrain";
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            check_eq("idle_grant", int'(grant), 0);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check_eq("post_start_grant", int'(grant), 0);

        // Randomized traffic, light then heavy freeze
        phase = "rand_a";
        for (int n = 0; n < 250; n++)
            step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 2));
        phase = "rand_b";
        do_reset();
        step(4'b0000, 1'b1, 1'b0);
        for (int n = 0; n < 250; n++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
